// File: rtl/ec_pkg.sv
// Shared types for the EC ElGamal encryptor: FSM states, projective point
// struct and the identity point constant.
package ec_pkg;

   // Coordinate width carried by point_t; the N parameter of the blocks
   // using this package is expected to match it.
   localparam int EC_N = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DBL,
      S_ADD,
      S_FIN
   } state_t;

   typedef struct packed {
      logic [EC_N-1:0] x;
      logic [EC_N-1:0] y;
      logic [EC_N-1:0] z;
   } point_t;

   // Identity O = (0,1,0)
   function automatic point_t pt_identity();
      point_t p;
      p.x = '0;
      p.y = EC_N'(1);
      p.z = '0;
      return p;
   endfunction

endpackage

// File: rtl/ec_elgamal_encrypt_if.sv
// Request/response bundle of the EC ElGamal encryptor.
interface ec_elgamal_encrypt_if #(
   parameter int N = 8,
   parameter int K = 8
);
   logic         start;
   logic [K-1:0] r_scalar;
   logic [N-1:0] gx, gy, gz;
   logic [N-1:0] qx, qy, qz;
   logic [N-1:0] mx, my, mz;
   logic         busy;
   logic         done;
   logic [N-1:0] c1x, c1y, c1z;
   logic [N-1:0] c2x, c2y, c2z;

   modport master (
      output start, r_scalar, gx, gy, gz, qx, qy, qz, mx, my, mz,
      input  busy, done, c1x, c1y, c1z, c2x, c2y, c2z
   );

   modport slave (
      input  start, r_scalar, gx, gy, gz, qx, qy, qz, mx, my, mz,
      output busy, done, c1x, c1y, c1z, c2x, c2y, c2z
   );
endinterface

// File: rtl/ec_point_add.sv
// Combinational complete projective point addition on y^2 = x^3 + a*x + b
// (Renes-Costello-Batina, general a). Handles doubling, inverse pairs and the
// identity without branching on the operands.
module ec_point_add import ec_pkg::*; #(
   parameter int N  = 8,
   parameter int P  = 97,
   parameter int A  = 2,
   parameter int B3 = 9
) (
   input  point_t p1,
   input  point_t p2,
   output point_t p3
);

   typedef logic [N-1:0] fe_t;

   localparam logic [N:0]     PN1 = (N+1)'(P);
   localparam logic [2*N-1:0] PN2 = (2*N)'(P);
   localparam fe_t            AC  = N'(A);
   localparam fe_t            BC  = N'(B3);

   function automatic fe_t fadd(fe_t a, fe_t b);
      logic [N:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= PN1) s = s - PN1;
      return s[N-1:0];
   endfunction

   // a<b wraps in N+1 bits; adding P brings it back into [0,P)
   function automatic fe_t fsub(fe_t a, fe_t b);
      logic [N:0] s;
      s = {1'b0, a} - {1'b0, b};
      if (a < b) s = s + PN1;
      return s[N-1:0];
   endfunction

   function automatic fe_t fmul(fe_t a, fe_t b);
      logic [2*N-1:0] pr;
      pr = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      pr = pr % PN2;
      return pr[N-1:0];
   endfunction

   fe_t x1, y1, z1, x2, y2, z2;
   fe_t t0, t1, t2, t3, t4, t5, x3, y3, z3;

   // Straight-line formula; temporaries are reused in the published order
   always_comb begin
      x1 = p1.x; y1 = p1.y; z1 = p1.z;
      x2 = p2.x; y2 = p2.y; z2 = p2.z;
      t0 = fmul(x1, x2);
      t1 = fmul(y1, y2);
      t2 = fmul(z1, z2);
      t3 = fsub(fmul(fadd(x1, y1), fadd(x2, y2)), fadd(t0, t1));
      t4 = fsub(fmul(fadd(x1, z1), fadd(x2, z2)), fadd(t0, t2));
      t5 = fsub(fmul(fadd(y1, z1), fadd(y2, z2)), fadd(t1, t2));
      z3 = fadd(fmul(AC, t4), fmul(BC, t2));
      x3 = fsub(t1, z3);
      z3 = fadd(t1, z3);
      y3 = fmul(x3, z3);
      t1 = fadd(fadd(t0, t0), t0);
      t2 = fmul(AC, t2);
      t4 = fmul(BC, t4);
      t1 = fadd(t1, t2);
      t2 = fmul(AC, fsub(t0, t2));
      t4 = fadd(t4, t2);
      y3 = fadd(y3, fmul(t1, t4));
      x3 = fsub(fmul(t3, x3), fmul(t5, t4));
      z3 = fadd(fmul(t5, z3), fmul(t3, t1));
      p3.x = x3;
      p3.y = y3;
      p3.z = z3;
   end

endmodule

// File: rtl/ec_elgamal_encrypt.sv
// EC ElGamal encryption: C1 = r*G, C2 = M + r*Q. Two parallel MSB-first
// double-and-always-add ladders share the scalar; fixed 2K+1 cycle latency.
module ec_elgamal_encrypt import ec_pkg::*; #(
   parameter int N  = 8,
   parameter int K  = 8,
   parameter int P  = 97,
   parameter int A  = 2,
   parameter int B3 = 9
) (
   input logic            clk,
   input logic            reset,
   ec_elgamal_encrypt_if.slave bus
);

   localparam int IW = (K > 1) ? $clog2(K) : 1;

   state_t         state;
   logic [K-1:0]   r_lat;
   logic [IW-1:0]  idx;
   point_t         g, q, m, rg, rq, c1, c2;
   point_t         gop1, gop2, qop1, qop2, sum_g, sum_q;
   logic           busy_r, done_r;

   // Operand steering: DBL doubles, ADD adds the base, FIN forms M + RQ
   always_comb begin
      gop1 = rg;
      gop2 = (state == S_DBL) ? rg : g;
      qop1 = (state == S_FIN) ? m : rq;
      qop2 = (state == S_ADD) ? q : rq;
   end

   ec_point_add #(.N(N), .P(P), .A(A), .B3(B3)) u_add_g (
      .p1(gop1), .p2(gop2), .p3(sum_g)
   );

   ec_point_add #(.N(N), .P(P), .A(A), .B3(B3)) u_add_q (
      .p1(qop1), .p2(qop2), .p3(sum_q)
   );

   // Control FSM and datapath registers; outputs only move at FIN or reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         c1     <= '0;
         c2     <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  r_lat  <= bus.r_scalar;
                  g      <= '{x: bus.gx, y: bus.gy, z: bus.gz};
                  q      <= '{x: bus.qx, y: bus.qy, z: bus.qz};
                  m      <= '{x: bus.mx, y: bus.my, z: bus.mz};
                  rg     <= pt_identity();
                  rq     <= pt_identity();
                  idx    <= IW'(K-1);
                  busy_r <= 1'b1;
                  state  <= S_DBL;
               end
            end
            S_DBL: begin
               rg    <= sum_g;
               rq    <= sum_q;
               state <= S_ADD;
            end
            S_ADD: begin
               // sum is always formed; only committed for a set bit
               if (r_lat[idx]) begin
                  rg <= sum_g;
                  rq <= sum_q;
               end
               if (idx == '0) begin
                  state <= S_FIN;
               end else begin
                  idx   <= idx - IW'(1);
                  state <= S_DBL;
               end
            end
            S_FIN: begin
               c1     <= rg;
               c2     <= sum_q;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.c1x  = c1.x;
   assign bus.c1y  = c1.y;
   assign bus.c1z  = c1.z;
   assign bus.c2x  = c2.x;
   assign bus.c2y  = c2.y;
   assign bus.c2z  = c2.z;

endmodule

// File: tb/tb_ec_elgamal_encrypt.sv
// Bench for ec_elgamal_encrypt: affine reference model with explicit
// special cases, cycle-level timing model, directed and random operations.
module tb_ec_elgamal_encrypt;
   localparam int N   = 8;
   localparam int K   = 8;
   localparam int P   = 97;
   localparam int A   = 2;
   localparam int B3  = 9;
   localparam int LAT = 2*K + 1;

   typedef struct { bit inf; int x; int y; } aff_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   ec_elgamal_encrypt_if #(.N(N), .K(K)) bus ();

   ec_elgamal_encrypt #(.N(N), .K(K), .P(P), .A(A), .B3(B3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- affine reference arithmetic ----------------
   function automatic int md(longint v);
      longint r;
      r = v % P;
      if (r < 0) r = r + P;
      return int'(r);
   endfunction

   function automatic int inv(int a);
      longint r, b;
      r = 1; b = a;
      for (int e = P - 2; e > 0; e = e >> 1) begin
         if (e[0]) r = (r * b) % P;
         b = (b * b) % P;
      end
      return int'(r);
   endfunction

   function automatic aff_t mk(bit inf, int x, int y);
      aff_t a;
      a.inf = inf; a.x = x; a.y = y;
      return a;
   endfunction

   function automatic aff_t aff_add(aff_t p, aff_t q);
      int l;
      if (p.inf) return q;
      if (q.inf) return p;
      if (p.x == q.x && md(p.y + q.y) == 0) return mk(1, 0, 0);
      if (p.x == q.x) l = md(longint'(md(3*p.x*p.x + A)) * inv(md(2*p.y)));
      else            l = md(longint'(md(q.y - p.y)) * inv(md(q.x - p.x)));
      return mk(0, md(longint'(l)*l - p.x - q.x),
                   md(longint'(l)*(p.x - md(longint'(l)*l - p.x - q.x)) - p.y));
   endfunction

   function automatic aff_t aff_mul(int k, aff_t p);
      aff_t s;
      s = mk(1, 0, 0);
      for (int i = 0; i < k; i++) s = aff_add(s, p);
      return s;
   endfunction

   function automatic aff_t to_aff(int x, int y, int z);
      if (z == 0) return mk(1, 0, 0);
      return mk(0, md(longint'(x) * inv(z)), md(longint'(y) * inv(z)));
   endfunction

   function automatic bit aeq(aff_t a, aff_t b);
      return (a.inf && b.inf) || (!a.inf && !b.inf && a.x == b.x && a.y == b.y);
   endfunction

   function automatic string astr(aff_t a);
      return a.inf ? "O" : $sformatf("(%0d,%0d)", a.x, a.y);
   endfunction

   function automatic aff_t dut_c1();
      return to_aff(int'(bus.c1x), int'(bus.c1y), int'(bus.c1z));
   endfunction

   function automatic aff_t dut_c2();
      return to_aff(int'(bus.c2x), int'(bus.c2y), int'(bus.c2z));
   endfunction

   task automatic chk(input string name, input bit ok, input string got, input string want);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s cycle %0d: actual %s, required %s", name, cyc, got, want);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   aff_t gA;
   aff_t mulG[5];

   task automatic proj(input aff_t a, input int l, output int x, output int y, output int z);
      if (a.inf) begin x = 0; y = l; z = 0; end
      else begin x = md(longint'(a.x) * l); y = md(longint'(a.y) * l); z = l; end
   endtask

   task automatic set_op(input int r, input aff_t qa, input int lq, input aff_t ma, input int lm);
      int x, y, z;
      bus.r_scalar = K'(r);
      bus.gx = N'(3); bus.gy = N'(6); bus.gz = N'(1);
      proj(qa, lq, x, y, z);
      bus.qx = N'(x); bus.qy = N'(y); bus.qz = N'(z);
      proj(ma, lm, x, y, z);
      bus.mx = N'(x); bus.my = N'(y); bus.mz = N'(z);
   endtask

   // Called at posedge+1 with the DUT idle; returns edges from accept to done
   task automatic run_op(output int lat);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
   endtask

   task automatic count_done(input int ncyc, output int cnt);
      cnt = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         if (bus.done) cnt++;
      end
   endtask

   // ---------------- cycle model + compare process ----------------
   bit   m_live = 0, m_busy = 0, m_done = 0, m_zero = 1;
   int   m_cnt  = 0;
   aff_t pend1, pend2, exp1, exp2;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            m_busy = 0; m_done = 0; m_zero = 1; m_live = 1;
         end else if (m_live) begin
            m_done = 0;
            if (m_busy) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_busy = 0; m_done = 1; m_zero = 0;
                  exp1 = pend1; exp2 = pend2;
               end
            end else if (bus.start) begin
               m_busy = 1;
               m_cnt  = LAT;
               pend1  = aff_mul(int'(bus.r_scalar),
                                to_aff(int'(bus.gx), int'(bus.gy), int'(bus.gz)));
               pend2  = aff_add(to_aff(int'(bus.mx), int'(bus.my), int'(bus.mz)),
                                aff_mul(int'(bus.r_scalar),
                                        to_aff(int'(bus.qx), int'(bus.qy), int'(bus.qz))));
            end
         end
         @(negedge clk);
         if (m_live) begin
            chk("busy", bus.busy == m_busy, $sformatf("%0b", bus.busy), $sformatf("%0b", m_busy));
            chk("done", bus.done == m_done, $sformatf("%0b", bus.done), $sformatf("%0b", m_done));
            if (m_zero) begin
               chk("outputs_zero",
                   {bus.c1x, bus.c1y, bus.c1z, bus.c2x, bus.c2y, bus.c2z} == '0,
                   $sformatf("%h", {bus.c1x, bus.c1y, bus.c1z, bus.c2x, bus.c2y, bus.c2z}), "0");
            end else begin
               chk("c1", aeq(dut_c1(), exp1), astr(dut_c1()), astr(exp1));
               chk("c2", aeq(dut_c2(), exp2), astr(dut_c2()), astr(exp2));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int   lat, cnt, r, dq, dm;
      aff_t o, p80;

      bus.start = 1'b0;
      set_op(0, mk(1, 0, 0), 1, mk(1, 0, 0), 1);
      gA  = mk(0, 3, 6);
      o   = mk(1, 0, 0);
      p80 = mk(0, 80, 10);
      for (int k = 0; k < 5; k++) mulG[k] = aff_mul(k, gA);

      // model pins
      chk("model_2G", aeq(mulG[2], p80), astr(mulG[2]), "(80,10)");
      chk("model_3G", aeq(mulG[3], mk(0, 80, 87)), astr(mulG[3]), "(80,87)");
      chk("model_5G", aeq(aff_mul(5, gA), o), astr(aff_mul(5, gA)), "O");
      chk("model_norm", aeq(to_aff(15, 14, 79), p80), astr(to_aff(15, 14, 79)), "(80,10)");

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // r=1, Q=G, M=O
      set_op(1, gA, 1, o, 1);
      run_op(lat);
      chk("lat_r1", lat == LAT, $sformatf("%0d", lat), "17");
      chk("r1_c1", aeq(dut_c1(), gA), astr(dut_c1()), "(3,6)");
      chk("r1_c2", aeq(dut_c2(), gA), astr(dut_c2()), "(3,6)");

      // r=2, M=O (scaled)
      set_op(2, gA, 1, o, 5);
      run_op(lat);
      chk("r2_c1", aeq(dut_c1(), p80), astr(dut_c1()), "(80,10)");
      chk("r2_c2", aeq(dut_c2(), p80), astr(dut_c2()), "(80,10)");

      // r=1, M=G: FIN doubles through the adder
      set_op(1, gA, 1, gA, 1);
      run_op(lat);
      chk("mg_c1", aeq(dut_c1(), gA), astr(dut_c1()), "(3,6)");
      chk("mg_c2", aeq(dut_c2(), p80), astr(dut_c2()), "(80,10)");

      // r=0
      set_op(0, gA, 1, p80, 1);
      run_op(lat);
      chk("lat_r0", lat == LAT, $sformatf("%0d", lat), "17");
      chk("r0_c1z", bus.c1z == '0, $sformatf("%0d", bus.c1z), "0");
      chk("r0_c2", aeq(dut_c2(), p80), astr(dut_c2()), "(80,10)");

      // start pulsed again at edge 5: exactly one done
      set_op(3, mulG[2], 2, mulG[1], 3);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      count_done(40, cnt);
      chk("one_done", cnt == 1, $sformatf("%0d", cnt), "1");

      // reset at edge 8 abandons the operation
      set_op(7, mulG[3], 4, mulG[4], 9);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("rst_busy", bus.busy == 1'b0, $sformatf("%0b", bus.busy), "0");
      chk("rst_c1x", bus.c1x == '0, $sformatf("%0d", bus.c1x), "0");
      count_done(30, cnt);
      chk("rst_no_done", cnt == 0, $sformatf("%0d", cnt), "0");

      // start together with reset is ignored
      reset = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1 reset = 1'b0; bus.start = 1'b0;
      chk("rst_start", bus.busy == 1'b0, $sformatf("%0b", bus.busy), "0");
      repeat (2) @(posedge clk);
      #1;

      // start held high across done; inputs change while busy
      set_op(2, mulG[1], 1, mulG[3], 2);
      bus.start = 1'b1;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1 set_op(4, mulG[2], 6, mulG[1], 1);
      lat = 0;
      for (int i = 4; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
      chk("hold_lat1", lat == LAT, $sformatf("%0d", lat), "17");
      @(posedge clk); #1 bus.start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = i; break; end
      end
      chk("hold_lat2", lat == LAT, $sformatf("%0d", lat), "17");

      // randomized operations
      for (int it = 0; it < 40; it++) begin
         r  = int'($urandom_range(0, 255));
         dq = int'($urandom_range(0, 4));
         dm = int'($urandom_range(0, 4));
         set_op(r, mulG[dq], int'($urandom_range(1, 96)), mulG[dm], int'($urandom_range(1, 96)));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if (it % 10 == 9) begin
            bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            repeat ($urandom_range(1, 15)) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
         end else begin
            run_op(lat);
            chk("rand_lat", lat == LAT, $sformatf("%0d", lat), "17");
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
